// File: rtl/sb_pkg.sv
// Shared streambuffer types and constants used by the input and output sides.
package sb_pkg;

  localparam int unsigned IBYTES = 4;
  localparam int unsigned OOPT   = 4;
  localparam int unsigned OPT_W  = (OOPT > 1) ? $clog2(OOPT) : 1;

  typedef logic [7:0]       byte_t;
  typedef logic [OPT_W-1:0] opt_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sb_out_arbiter_if.sv
// Consumer / streambuffer handshake bundle around the output arbiter.
interface sb_out_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  import sb_pkg::*;

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       rreq;
  opt_t [NREQ-1:0]       ropt;
  logic [NREQ-1:0]       rready;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rvalid;
  logic [OOPT-1:0]       sb_ovalid;
  logic [OOPT-1:0]       sb_oready;
  logic                  busy;
  logic [IW-1:0]         owner;

  modport master (
    output rreq, ropt, rready, sb_ovalid,
    input  gnt, rvalid, sb_oready, busy, owner
  );

  modport slave (
    input  rreq, ropt, rready, sb_ovalid,
    output gnt, rvalid, sb_oready, busy, owner
  );

endinterface

// File: rtl/sb_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Scan downward so the candidate closest to ptr is the last one written.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((32'(ptr) + 32'(k)) % NREQ);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/sb_out_arbiter.sv
// Round-robin owner of the streambuffer output side with bounded bursts per grant.
module sb_out_arbiter
  import sb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  sb_out_arbiter_if.slave bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BW = $clog2(BURST + 1);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   owner_q, rr_ptr_q, pick_idx, rr_next;
  opt_t            opt_q;
  logic [BW-1:0]   beats_q;
  logic [NREQ-1:0] gnt_q;
  logic            pick_any;
  logic            beat_c, release_c;
  logic [OOPT-1:0] oready_c;
  logic [NREQ-1:0] rvalid_c;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (bus.rreq),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any)  state_d = GRANT;
      GRANT:   if (release_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake steering; gated in the reset cycle so no beat escapes unreported.
  always_comb begin
    oready_c  = '0;
    rvalid_c  = '0;
    beat_c    = 1'b0;
    release_c = 1'b0;
    if (state_q == GRANT && !rst) begin
      oready_c[opt_q]   = bus.rready[owner_q] & bus.rreq[owner_q];
      beat_c            = oready_c[opt_q] & bus.sb_ovalid[opt_q];
      rvalid_c[owner_q] = beat_c;
      release_c         = !bus.rreq[owner_q] || (beat_c && beats_q == BW'(BURST - 1));
    end
  end

  assign rr_next = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= '0;
      opt_q    <= '0;
      beats_q  <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
    end else if (state_q == IDLE) begin
      if (pick_any) begin
        owner_q <= pick_idx;
        opt_q   <= bus.ropt[pick_idx];
        beats_q <= '0;
        gnt_q   <= NREQ'(1) << pick_idx;
      end
    end else begin
      if (beat_c && !release_c) beats_q <= beats_q + BW'(1);
      if (release_c) begin
        gnt_q    <= '0;
        rr_ptr_q <= rr_next;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_c;
  assign bus.sb_oready = oready_c;
  assign bus.busy      = (state_q == GRANT);
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_sb_out_arbiter.sv
// Directed bench for sb_out_arbiter with a grant-order scoreboard and per-cycle invariants.
module tb_sb_out_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mon_en = 1'b0;
  logic [3:0] prev_gnt = 4'h0;

  int n_checks = 0;
  int n_err    = 0;
  int sb_q[$];

  logic [3:0] eg[$];
  logic [3:0] eo[$];
  logic [3:0] ev[$];

  always #5 clk = ~clk;

  sb_out_arbiter_if #(.NREQ(4)) bus ();

  sb_out_arbiter #(.NREQ(4), .BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string s, input int c, input logic [3:0] xg,
                         input logic [3:0] xo, input logic [3:0] xv);
    chk($sformatf("%s_c%0d_gnt", s, c), 32'(bus.gnt), 32'(xg));
    chk($sformatf("%s_c%0d_oready", s, c), 32'(bus.sb_oready), 32'(xo));
    chk($sformatf("%s_c%0d_rvalid", s, c), 32'(bus.rvalid), 32'(xv));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst           = 1'b1;
    bus.rreq      = '0;
    bus.rready    = '0;
    bus.sb_ovalid = '0;
    bus.ropt      = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Invariants every cycle, plus grant order against the scoreboard on each new grant.
  always @(negedge clk) begin : monitor
    int unsigned ow;
    if (mon_en) begin
      chk("inv_gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      chk("inv_oready_onehot0", 32'($onehot0(bus.sb_oready)), 32'd1);
      chk("inv_rvalid_subset", 32'(bus.rvalid & ~bus.gnt), 32'd0);
      chk("inv_oready_busy", 32'((bus.sb_oready == 4'h0) || bus.busy), 32'd1);
      if (bus.gnt != 4'h0 && prev_gnt == 4'h0) begin
        if (sb_q.size() > 0) begin
          ow = int'(sb_q.pop_front());
          chk("sb_grant", 32'(bus.gnt), 32'(4'b0001 << ow));
          chk("sb_owner", 32'(bus.owner), ow);
        end else begin
          chk("sb_grant_unexpected", 32'(bus.gnt), 32'd0);
        end
      end
      prev_gnt <= bus.gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int ow;
    logic [3:0] xg, xo;

    do_reset();
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_oready", 32'(bus.sb_oready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);
    mon_en = 1'b1;

    // Single requester 1 on option 1, ovalid toggling; release after 4th beat then regrant.
    do_reset();
    sb_q.push_back(1);
    sb_q.push_back(1);
    eg = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h2};
    ev = '{4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h2};
    for (int c = 0; c < 10; c++) begin
      tick();
      bus.rreq      = 4'b0010;
      bus.ropt[1]   = 2'd1;
      bus.rready    = 4'b0010;
      bus.sb_ovalid = (c % 2 == 1) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      chk_cyc("s1", c, eg[c], eg[c], ev[c]);
    end

    // All four requesting at full rate: grants 0,1,2,3,0 each 4 beats + 1 bubble.
    do_reset();
    sb_q.push_back(0);
    sb_q.push_back(1);
    sb_q.push_back(2);
    sb_q.push_back(3);
    sb_q.push_back(0);
    for (int c = 0; c < 22; c++) begin
      tick();
      bus.rreq      = 4'b1111;
      bus.rready    = 4'b1111;
      bus.sb_ovalid = 4'b1111;
      for (int i = 0; i < 4; i++) bus.ropt[i] = 2'(3 - i);
      @(negedge clk);
      xg = 4'h0;
      xo = 4'h0;
      if (c >= 1 && ((c - 1) % 5) != 4) begin
        ow = ((c - 1) / 5) % 4;
        xg = 4'(1 << ow);
        xo = 4'(1 << (3 - ow));
      end
      chk_cyc("s2", c, xg, xo, xg);
    end

    // Owner 2 stalls on rready for 10 cycles after two beats, then finishes the burst.
    do_reset();
    sb_q.push_back(2);
    for (int c = 0; c < 16; c++) begin
      tick();
      bus.rreq      = (c < 15) ? 4'b0100 : 4'b0000;
      bus.ropt[2]   = 2'd2;
      bus.sb_ovalid = 4'b1111;
      bus.rready    = (c >= 3 && c <= 12) ? 4'b1011 : 4'b1111;
      @(negedge clk);
      xg = (c >= 1 && c <= 14) ? 4'b0100 : 4'b0000;
      xo = (c == 1 || c == 2 || c == 13 || c == 14) ? 4'b0100 : 4'b0000;
      chk_cyc("s3", c, xg, xo, xo);
    end

    // Owner 0 drops rreq after 2 beats and re-requests in the bubble; pointer favours 1.
    do_reset();
    sb_q.push_back(0);
    sb_q.push_back(1);
    eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2};
    eo = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    for (int c = 0; c < 6; c++) begin
      tick();
      bus.rready    = 4'b1111;
      bus.sb_ovalid = 4'b1111;
      bus.ropt      = '0;
      bus.rreq      = (c < 3) ? 4'b0011 : (c == 3) ? 4'b0010 : (c == 4) ? 4'b0011 : 4'b0000;
      @(negedge clk);
      chk_cyc("s4", c, eg[c], eo[c], eo[c]);
    end

    // ropt change mid-grant is ignored until the next grant; ovalid off-line is ignored.
    do_reset();
    sb_q.push_back(0);
    sb_q.push_back(0);
    eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1};
    eo = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8};
    ev = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1};
    for (int c = 0; c < 8; c++) begin
      tick();
      bus.rreq      = 4'b0001;
      bus.rready    = 4'b1111;
      bus.ropt[0]   = (c >= 2) ? 2'd3 : 2'd1;
      bus.sb_ovalid = (c == 2) ? 4'b1101 : 4'b1111;
      @(negedge clk);
      chk_cyc("s5", c, eg[c], eo[c], ev[c]);
    end

    // Reset during beat 3 of owner 2's burst; first grant afterwards goes to index 0.
    do_reset();
    sb_q.push_back(0);
    sb_q.push_back(2);
    sb_q.push_back(0);
    eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h1};
    eo = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1};
    ev = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h1};
    for (int c = 0; c < 11; c++) begin
      tick();
      bus.rreq      = 4'b0101;
      bus.rready    = 4'b1111;
      bus.sb_ovalid = 4'b1111;
      bus.ropt      = '0;
      rst           = (c == 8);
      @(negedge clk);
      chk($sformatf("s6_c%0d_gnt", c), 32'(bus.gnt), 32'(eg[c]));
      chk($sformatf("s6_c%0d_rvalid", c), 32'(bus.rvalid), 32'(ev[c]));
      if (c != 8) chk($sformatf("s6_c%0d_oready", c), 32'(bus.sb_oready), 32'(eo[c]));
      if (c == 9) begin
        chk("s6_post_rst_busy", 32'(bus.busy), 32'd0);
        chk("s6_post_rst_owner", 32'(bus.owner), 32'd0);
      end
    end

    tick();
    chk("sb_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
